// File: rtl/nrisc_mem_pkg.sv
// Shared types and defaults for the per-core DataMEM load/store initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nrisc_mem_pkg;

  localparam int TAM_DEF  = 16;
  localparam int LMEM_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic               we;
    logic [TAM_DEF-1:0] addr;
    logic [TAM_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Request, response and DataMEM port bundle for one core's load/store unit.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
interface mem_lsu_if #(
  parameter int TAM = nrisc_mem_pkg::TAM_DEF
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [TAM-1:0] req_addr;
  logic [TAM-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_we;
  logic [TAM-1:0] rsp_rdata;
  logic           rsp_err;
  logic           busy;
  logic [TAM-1:0] dataADDR;
  logic [TAM-1:0] dataIN;
  logic [TAM-1:0] dataOUT;
  logic           dataLoad;
  logic           dataWrite;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dataOUT,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, busy,
           dataADDR, dataIN, dataLoad, dataWrite
  );

  // Core pipeline plus DataMEM side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, dataOUT,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, busy,
           dataADDR, dataIN, dataLoad, dataWrite
  );
endinterface

// File: rtl/mem_req_fifo.sv
// In-order request buffer with full/empty flags; head is read straight from the storage registers.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; full ignores a same-cycle pop.
module mem_req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_lsu.sv
// Per-core DataMEM requester: buffers load/store requests and runs them one at a time, in order.
// Latency: accept to rsp_valid is 2+RD_LAT cycles (load), 2 (store), 1 (out-of-range), FSM idle.
// Backpressure: req_ready drops when the FIFO is full; rsp_ready low holds the response indefinitely.
module mem_lsu
  import nrisc_mem_pkg::*;
#(
  parameter int TAM        = TAM_DEF,
  parameter int Lmem       = LMEM_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input logic     clk,
  input logic     rst,
  mem_lsu_if.slave bus
);
  localparam int FW = 1 + 2 * TAM;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t         state;
  state_t         state_n;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FW-1:0]  fifo_head;
  logic           head_we;
  logic [TAM-1:0] head_addr;
  logic [TAM-1:0] head_wdata;
  logic           head_err;

  logic           op_we;
  logic           op_err;
  logic [TAM-1:0] op_rdata;
  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_wdata;
  logic           mem_load;
  logic           mem_write;
  logic [CW-1:0]  wait_cnt;

  mem_req_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.req_valid),
    .push_data({bus.req_we, bus.req_addr, bus.req_wdata}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_we, head_addr, head_wdata} = fifo_head;
  // Any address bit above the memory range makes the request an error.
  assign head_err = (head_addr[TAM-1:Lmem] != '0);

  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_we    = op_we;
  assign bus.rsp_err   = op_err;
  assign bus.rsp_rdata = op_rdata;
  assign bus.busy      = !fifo_empty || (state != IDLE);
  assign bus.dataADDR  = mem_addr;
  assign bus.dataIN    = mem_wdata;
  assign bus.dataLoad  = mem_load;
  assign bus.dataWrite = mem_write;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and FIFO pop; only one access is ever outstanding.
  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = head_err ? RESP : ISSUE;
        end
      end
      ISSUE:   state_n = op_we ? RESP : WAIT;
      WAIT:    if (wait_cnt == '0) state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Op register, memory strobes for the single ISSUE cycle, read-latency counter and load capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_we     <= 1'b0;
      op_err    <= 1'b0;
      op_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_load  <= 1'b0;
      mem_write <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            op_we    <= head_we;
            op_err   <= head_err;
            op_rdata <= '0;
            if (!head_err) begin
              mem_addr  <= head_addr;
              mem_wdata <= head_we ? head_wdata : '0;
              mem_write <= head_we;
              mem_load  <= !head_we;
            end
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
          mem_load  <= 1'b0;
          wait_cnt  <= CW'(RD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) op_rdata <= bus.dataOUT;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a one-cycle-latency DataMEM model and a memory scoreboard.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_lsu;
  import nrisc_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if #(.TAM(16)) bus ();

  mem_lsu #(
    .TAM(16),
    .Lmem(8),
    .FIFO_DEPTH(4),
    .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // DataMEM model: write committed at the sampling edge, load data valid one cycle later.
  logic [15:0] dmem [256] = '{default: '0};
  always @(posedge clk) begin
    if (bus.dataWrite) dmem[bus.dataADDR[7:0]] <= bus.dataIN;
    if (bus.dataLoad)  bus.dataOUT <= dmem[bus.dataADDR[7:0]];
  end

  // Strobe and response-handshake counters.
  int n_load  = 0;
  int n_write = 0;
  int n_rsp   = 0;
  bit both_seen = 1'b0;
  always @(posedge clk) begin
    if (bus.dataLoad  === 1'b1) n_load  <= n_load + 1;
    if (bus.dataWrite === 1'b1) n_write <= n_write + 1;
    if (bus.dataLoad === 1'b1 && bus.dataWrite === 1'b1) both_seen <= 1'b1;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) n_rsp <= n_rsp + 1;
  end

  logic [15:0] sb [256] = '{default: '0};

  // Present a request from a falling edge; returns at the falling edge after the accept edge.
  task automatic push(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_timeout addr=%h req_ready=%b required=1", addr, bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Count falling edges from the one after the accept edge until rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0005;
    bus.req_wdata = 16'hAAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if ({bus.dataWrite, bus.dataLoad} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {bus.dataWrite, bus.dataLoad}); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== 18'h0) begin failures++; $display("FAIL reset_rsp_fields got=%h exp=0", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}); end
    checks++; if ({bus.dataADDR, bus.dataIN} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", {bus.dataADDR, bus.dataIN}); end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00 || n_write != 0) begin
      failures++; $display("FAIL reset_no_push busy_valid=%b writes=%0d exp=00/0", {bus.busy, bus.rsp_valid}, n_write);
    end
  endtask

  task automatic test_store_load();
    int lat;
    int w0 = n_write;
    int l0 = n_load;
    push(1'b1, 16'h0012, 16'hBEEF);
    wait_rsp(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", lat); end
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL store_rsp got=%h exp=%h", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, 16'h0000});
    end
    @(posedge clk); @(negedge clk);
    checks++; if (n_write != w0 + 1 || n_load != l0) begin failures++; $display("FAIL store_strobes writes=%0d loads=%0d exp=%0d/%0d", n_write, n_load, w0 + 1, l0); end
    checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL store_done valid_busy=%b exp=00", {bus.rsp_valid, bus.busy}); end
    push(1'b0, 16'h0012, 16'h0000);
    wait_rsp(lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== {1'b0, 1'b0, 16'hBEEF}) begin
      failures++; $display("FAIL load_rsp got=%h exp=%h", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, {1'b0, 1'b0, 16'hBEEF});
    end
    @(posedge clk); @(negedge clk);
    checks++; if (n_load != l0 + 1) begin failures++; $display("FAIL load_strobe loads=%0d exp=%0d", n_load, l0 + 1); end
  endtask

  task automatic test_out_of_range();
    int lat;
    int l0 = n_load;
    push(1'b0, 16'h0100, 16'h0000);
    wait_rsp(lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== {1'b0, 1'b1, 16'h0000}) begin
      failures++; $display("FAIL err_rsp got=%h exp=%h", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, {1'b0, 1'b1, 16'h0000});
    end
    @(posedge clk); @(negedge clk);
    checks++; if (n_load != l0) begin failures++; $display("FAIL err_no_load loads=%0d exp=%0d", n_load, l0); end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp_rsp [5];
    int lat;
    int r0;
    exp_rsp[0] = {1'b1, 1'b0, 16'h0000};
    exp_rsp[1] = {1'b0, 1'b0, 16'h1111};
    exp_rsp[2] = {1'b1, 1'b0, 16'h0000};
    exp_rsp[3] = {1'b0, 1'b0, 16'h2222};
    exp_rsp[4] = {1'b0, 1'b1, 16'h0000};
    bus.rsp_ready = 1'b0;
    r0 = n_rsp;
    push(1'b1, 16'h0030, 16'h1111);
    push(1'b0, 16'h0030, 16'h0000);
    push(1'b1, 16'h0031, 16'h2222);
    push(1'b0, 16'h0031, 16'h0000);
    push(1'b0, 16'h0200, 16'h0000);
    repeat (4) @(negedge clk);
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 3'b011) begin
      failures++; $display("FAIL full_flags ready_valid_busy=%b exp=011", {bus.req_ready, bus.rsp_valid, bus.busy});
    end
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== exp_rsp[0]) begin
      failures++; $display("FAIL held_rsp got=%h exp=%h", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, exp_rsp[0]);
    end
    // A sixth request is offered while full and must not be taken.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0032;
    bus.req_wdata = 16'h3333;
    repeat (5) @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if ({bus.req_ready, bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== {1'b0, exp_rsp[0]}) begin
      failures++; $display("FAIL full_stable got=%h exp=%h", {bus.req_ready, bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, {1'b0, exp_rsp[0]});
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat);
      checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== exp_rsp[i]) begin
        failures++; $display("FAIL drain_rsp%0d got=%h exp=%h", i, {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, exp_rsp[i]);
      end
      @(posedge clk); @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (n_rsp != r0 + 5 || {bus.busy, bus.rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL drain_count rsps=%0d busy_valid=%b exp=%0d/00", n_rsp - r0, {bus.busy, bus.rsp_valid}, 5);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int w0;
    push(1'b0, 16'h0012, 16'h0000);
    push(1'b1, 16'h0040, 16'h5555);
    @(posedge clk); @(negedge clk);
    w0 = n_write;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({bus.dataLoad, bus.dataWrite, bus.rsp_valid, bus.busy, bus.req_ready} !== 5'b00001) begin
      failures++; $display("FAIL midrst_state load_write_valid_busy_ready=%b exp=00001", {bus.dataLoad, bus.dataWrite, bus.rsp_valid, bus.busy, bus.req_ready});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || n_write != w0) begin failures++; $display("FAIL midrst_discard busy=%b writes=%0d exp=0/%0d", bus.busy, n_write, w0); end
    push(1'b0, 16'h0040, 16'h0000);
    wait_rsp(lat);
    checks++; if (lat != 3 || {bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== 18'h0) begin
      failures++; $display("FAIL midrst_load40 lat=%0d got=%h exp=3/0", lat, {bus.rsp_we, bus.rsp_err, bus.rsp_rdata});
    end
    @(posedge clk); @(negedge clk);
    push(1'b0, 16'h0012, 16'h0000);
    wait_rsp(lat);
    checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== {1'b0, 1'b0, 16'hBEEF}) begin
      failures++; $display("FAIL midrst_load12 got=%h exp=%h", {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, {1'b0, 1'b0, 16'hBEEF});
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [17:0] exp;
    sb[8'h12] = 16'hBEEF;
    sb[8'h30] = 16'h1111;
    sb[8'h31] = 16'h2222;
    for (int i = 0; i < 1000; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom_range(0, 255));
      wdata = 16'($urandom);
      push(we, {8'h00, addr}, wdata);
      wait_rsp(lat);
      exp = we ? {1'b1, 1'b0, 16'h0000} : {1'b0, 1'b0, sb[addr]};
      if (we) sb[addr] = wdata;
      checks++; if ({bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== exp) begin
        failures++; $display("FAIL random_op%0d addr=%h got=%h exp=%h", i, addr, {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, exp);
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL strobe_exclusive both_seen=%b exp=0", both_seen); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
